// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy/fill engine: widths, FSM states, modes.
package mem_copy_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 13;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Single-port data memory bus driven by the copy engine.
interface mem_copy_engine_if;
  import mem_copy_pkg::*;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rdata;

  // Engine side: owns the address/control, consumes read data.
  modport master (
    output mem_rd,
    output mem_wr,
    output mem_addr,
    output mem_wd,
    input  mem_rdata
  );

  // Memory side.
  modport slave (
    input  mem_rd,
    input  mem_wr,
    input  mem_addr,
    input  mem_wd,
    output mem_rdata
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / block fill engine. One memory access per cycle; copy alternates
// READ and WRITE, fill issues back-to-back WRITEs. All memory-side outputs are
// registers loaded alongside the next state, so start/abort/len never reach
// the memory port combinationally.
module mem_copy_engine
  import mem_copy_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  mem_copy_engine_if.master mem
);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [LEN_W-1:0]  r_words_done;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wd;

  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [LEN_W-1:0]  r_len;
  logic              r_mode;
  logic [DATA_W-1:0] r_fill;

  logic [LEN_W-1:0]  w_words_next;
  logic [ADDR_W-1:0] w_src_inc;
  logic [ADDR_W-1:0] w_dst_inc;

  // Pointer arithmetic wraps naturally at 2^ADDR_W.
  assign w_words_next = r_words_done + 1'b1;
  assign w_src_inc    = r_src_ptr + 1'b1;
  assign w_dst_inc    = r_dst_ptr + 1'b1;

  // FSM, command registers and registered memory-port outputs. Command and
  // pointer registers are left out of reset: they are always reloaded on start.
  // In copy mode the write-data register doubles as the read data buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_words_done <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wd     <= '0;
    end else begin
      r_done     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_src_ptr    <= src_addr;
            r_dst_ptr    <= dst_addr;
            r_len        <= len;
            r_mode       <= mode;
            r_fill       <= fill_val;
            r_words_done <= '0;
            r_busy       <= 1'b1;
            if (len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (mode == MODE_COPY) begin
              r_state    <= READ;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= src_addr;
            end else begin
              r_state    <= WRITE;
              r_mem_wr   <= 1'b1;
              r_mem_addr <= dst_addr;
              r_mem_wd   <= fill_val;
            end
          end
        end
        READ: begin
          // The read completes this cycle regardless of abort.
          r_src_ptr <= w_src_inc;
          if (abort) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= WRITE;
            r_mem_wr   <= 1'b1;
            r_mem_addr <= r_dst_ptr;
            r_mem_wd   <= mem.mem_rdata;
          end
        end
        WRITE: begin
          // The write commits at this edge, so it is always counted.
          r_dst_ptr    <= w_dst_inc;
          r_words_done <= w_words_next;
          if (abort || (w_words_next == r_len)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (r_mode == MODE_COPY) begin
            r_state    <= READ;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_src_ptr;
          end else begin
            r_state    <= WRITE;
            r_mem_wr   <= 1'b1;
            r_mem_addr <= w_dst_inc;
            r_mem_wd   <= r_fill;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign words_done   = r_words_done;
  assign mem.mem_rd   = r_mem_rd;
  assign mem.mem_wr   = r_mem_wr;
  assign mem.mem_addr = r_mem_addr;
  assign mem.mem_wd   = r_mem_wd;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural memory.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_val;
  logic              abort;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_done;

  mem_copy_engine_if u_if ();

  mem_copy_engine u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_val   (fill_val),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .mem        (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on rising edge.
  logic [DATA_W-1:0] mem_arr [0:(1<<ADDR_W)-1];
  logic              mem_init;

  assign u_if.mem_rdata = mem_arr[u_if.mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << ADDR_W); i++)
        mem_arr[i] <= 16'h1000 + 16'(i * 3);
      mem_arr[0] <= 16'h0002;
      mem_arr[1] <= 16'h0008;
      mem_arr[2] <= 16'h0040;
    end else if (u_if.mem_wr) begin
      mem_arr[u_if.mem_addr] <= u_if.mem_wd;
    end
  end

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle observations of the last command, indexed by cycle number.
  logic              c_busy [0:63];
  logic              c_done [0:63];
  logic              c_rd   [0:63];
  logic              c_wr   [0:63];
  logic [ADDR_W-1:0] c_addr [0:63];
  logic [DATA_W-1:0] c_wd   [0:63];
  logic [LEN_W-1:0]  c_wdn  [0:63];
  int                done_cyc;
  int                n_rd;
  int                n_wr;
  int                n_done;

  // Issue one command (accepted at edge 0) and observe cycles 1..last_c.
  // abort_c / rst_c / restart_c select the cycle in which abort, reset or a
  // second (ignored) start is asserted; 0 disables each.
  task automatic run_cmd(input logic m, input logic [ADDR_W-1:0] s,
                         input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] l,
                         input logic [DATA_W-1:0] f, input int abort_c,
                         input int rst_c, input int restart_c, input int last_c);
    done_cyc = -1;
    n_rd     = 0;
    n_wr     = 0;
    n_done   = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      c_busy[c] = busy;
      c_done[c] = done;
      c_rd[c]   = u_if.mem_rd;
      c_wr[c]   = u_if.mem_wr;
      c_addr[c] = u_if.mem_addr;
      c_wd[c]   = u_if.mem_wd;
      c_wdn[c]  = words_done;
      if (u_if.mem_rd) n_rd++;
      if (u_if.mem_wr) n_wr++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == abort_c) abort = 1'b1;
      if (c == rst_c) rst_n = 1'b0;
      if (c == restart_c) begin
        start = 1'b1; mode = MODE_FILL; src_addr = 12'd0; dst_addr = 12'd700;
        len = 13'd1; fill_val = 16'hDEAD;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      rst_n = 1'b1;
      start = 1'b0;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_val = '0; abort = 1'b0; mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_words", 32'(words_done), 32'd0);
    chk("rst_rd", 32'(u_if.mem_rd), 32'd0);
    chk("rst_wr", 32'(u_if.mem_wr), 32'd0);
    chk("rst_addr", 32'(u_if.mem_addr), 32'd0);
    chk("rst_wd", 32'(u_if.mem_wd), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Copy 3 words 0 -> 100.
    run_cmd(MODE_COPY, 12'd0, 12'd100, 13'd3, 16'h0, 0, 0, 0, 9);
    chk("cp_done_cyc", 32'(done_cyc), 32'd7);
    chk("cp_n_done", 32'(n_done), 32'd1);
    chk("cp_busy1", 32'(c_busy[1]), 32'd1);
    chk("cp_busy6", 32'(c_busy[6]), 32'd1);
    chk("cp_busy8", 32'(c_busy[8]), 32'd0);
    chk("cp_c1_rd", 32'(c_rd[1]), 32'd1);
    chk("cp_c1_addr", 32'(c_addr[1]), 32'd0);
    chk("cp_c2_wr", 32'(c_wr[2]), 32'd1);
    chk("cp_c2_addr", 32'(c_addr[2]), 32'd100);
    chk("cp_c2_wd", 32'(c_wd[2]), 32'h0002);
    chk("cp_c7_addr", 32'(c_addr[7]), 32'd0);
    chk("cp_n_rd", 32'(n_rd), 32'd3);
    chk("cp_n_wr", 32'(n_wr), 32'd3);
    chk("cp_words", 32'(words_done), 32'd3);
    chk("cp_m100", 32'(mem_arr[100]), 32'h0002);
    chk("cp_m101", 32'(mem_arr[101]), 32'h0008);
    chk("cp_m102", 32'(mem_arr[102]), 32'h0040);

    // Fill 4 words from 4094 with wrap.
    run_cmd(MODE_FILL, 12'd0, 12'd4094, 13'd4, 16'hBEEF, 0, 0, 0, 7);
    chk("fl_done_cyc", 32'(done_cyc), 32'd5);
    chk("fl_n_rd", 32'(n_rd), 32'd0);
    chk("fl_n_wr", 32'(n_wr), 32'd4);
    chk("fl_c3_addr", 32'(c_addr[3]), 32'd0);
    chk("fl_words", 32'(words_done), 32'd4);
    chk("fl_m4094", 32'(mem_arr[4094]), 32'hBEEF);
    chk("fl_m4095", 32'(mem_arr[4095]), 32'hBEEF);
    chk("fl_m0", 32'(mem_arr[0]), 32'hBEEF);
    chk("fl_m1", 32'(mem_arr[1]), 32'hBEEF);
    chk("fl_m2", 32'(mem_arr[2]), 32'h0040);
    chk("fl_m4093", 32'(mem_arr[4093]), 32'h3FF7);

    // Zero-length command.
    run_cmd(MODE_COPY, 12'd5, 12'd6, 13'd0, 16'h0, 0, 0, 0, 3);
    chk("z_done_cyc", 32'(done_cyc), 32'd1);
    chk("z_busy1", 32'(c_busy[1]), 32'd1);
    chk("z_busy2", 32'(c_busy[2]), 32'd0);
    chk("z_n_rd", 32'(n_rd), 32'd0);
    chk("z_n_wr", 32'(n_wr), 32'd0);
    chk("z_words", 32'(words_done), 32'd0);

    // Copy 10 words with abort in the third WRITE (cycle 6).
    run_cmd(MODE_COPY, 12'd200, 12'd300, 13'd10, 16'h0, 6, 0, 0, 10);
    chk("ab_done_cyc", 32'(done_cyc), 32'd7);
    chk("ab_n_rd", 32'(n_rd), 32'd3);
    chk("ab_n_wr", 32'(n_wr), 32'd3);
    chk("ab_c7_rd", 32'(c_rd[7]), 32'd0);
    chk("ab_words", 32'(words_done), 32'd3);
    chk("ab_m300", 32'(mem_arr[300]), 32'h1258);
    chk("ab_m301", 32'(mem_arr[301]), 32'h125B);
    chk("ab_m302", 32'(mem_arr[302]), 32'h125E);
    chk("ab_m303", 32'(mem_arr[303]), 32'h138D);

    // Copy 5 words, reset in cycle 4 (second WRITE).
    run_cmd(MODE_COPY, 12'd10, 12'd400, 13'd5, 16'h0, 0, 4, 0, 9);
    chk("rs_n_done", 32'(n_done), 32'd0);
    chk("rs_busy5", 32'(c_busy[5]), 32'd0);
    chk("rs_rd5", 32'(c_rd[5]), 32'd0);
    chk("rs_wr5", 32'(c_wr[5]), 32'd0);
    chk("rs_addr5", 32'(c_addr[5]), 32'd0);
    chk("rs_wd5", 32'(c_wd[5]), 32'd0);
    chk("rs_words5", 32'(c_wdn[5]), 32'd0);
    chk("rs_busy9", 32'(c_busy[9]), 32'd0);
    chk("rs_m400", 32'(mem_arr[400]), 32'h101E);
    chk("rs_m401", 32'(mem_arr[401]), 32'h1021);
    chk("rs_m402", 32'(mem_arr[402]), 32'h14B6);

    // Normal command after the reset.
    run_cmd(MODE_FILL, 12'd0, 12'd500, 13'd2, 16'h1234, 0, 0, 0, 5);
    chk("pr_done_cyc", 32'(done_cyc), 32'd3);
    chk("pr_words", 32'(words_done), 32'd2);
    chk("pr_m500", 32'(mem_arr[500]), 32'h1234);
    chk("pr_m501", 32'(mem_arr[501]), 32'h1234);

    // Second start mid-copy must be ignored.
    run_cmd(MODE_COPY, 12'd20, 12'd600, 13'd2, 16'h0, 0, 0, 2, 8);
    chk("rt_done_cyc", 32'(done_cyc), 32'd5);
    chk("rt_n_done", 32'(n_done), 32'd1);
    chk("rt_n_rd", 32'(n_rd), 32'd2);
    chk("rt_words", 32'(words_done), 32'd2);
    chk("rt_m600", 32'(mem_arr[600]), 32'h103C);
    chk("rt_m601", 32'(mem_arr[601]), 32'h103F);
    chk("rt_m700", 32'(mem_arr[700]), 32'h1834);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
